ultrasonic_sequencer: RTL
=========================

ULTRASONIC_SEQUENCER -- requirements
Module: ultrasonic_sequencer

Interface
REQ-001 SHALL have parameter TRIG_CYCLES, default 10, meaning the trig pulse width in clocks.
REQ-002 SHALL have parameter PRESCALE, default 58, meaning clocks per echo count tick.
REQ-003 SHALL have parameter ECHO_TIMEOUT, default 30000, meaning the maximum clocks spent waiting for the echo rising edge.
REQ-004 SHALL have parameter PERIOD_CYCLES, default 60000, meaning the minimum clocks from one trig rise to the next.
REQ-005 SHALL have parameter DIV_TIMEOUT, default 16, meaning the maximum clocks to wait for div_done.
REQ-006 SHALL have port: CLKOUTD  in  1  single system clock, rising edge.
REQ-007 SHALL have port: reset  in  1  asynchronous, active-low reset.
REQ-008 SHALL have port: start  in  1  level; while high, measurements repeat.
REQ-009 SHALL have port: echo  in  1  asynchronous sensor echo.
REQ-010 SHALL have port: trig  out  1  sensor trigger pulse.
REQ-011 SHALL have port: div_clr  out  1  active-high clear to the divider.
REQ-012 SHALL have port: calculate  out  1  divider request.
REQ-013 SHALL have port: count  out  8  echo tick count presented to the divider.
REQ-014 SHALL have port: div_done  in  1  divider complete (sticky until cleared).
REQ-015 SHALL have port: div_d  in  8  divider result.
REQ-016 SHALL have port: distance  out  8  last valid result.
REQ-017 SHALL have port: valid  out  1  one-cycle pulse when distance updates.
REQ-018 SHALL have port: timeout  out  1  one-cycle pulse on an aborted measurement.
REQ-019 SHALL have port: busy  out  1  high in every state except IDLE.

Function
REQ-020 SHALL synchronize echo through two flops; all echo decisions SHALL use the synchronized value.
REQ-021 SHALL implement states IDLE, TRIG, WAIT_ECHO, MEASURE, CLR, CALC, HOLD.
REQ-022 SHALL transition IDLE->TRIG when start=1; trig SHALL be high for exactly TRIG_CYCLES clocks in TRIG.
REQ-023 SHALL transition TRIG->WAIT_ECHO and then, on a synchronized echo rise, ->MEASURE.
REQ-024 SHALL, if ECHO_TIMEOUT clocks elapse in WAIT_ECHO, pulse timeout and go to HOLD.
REQ-025 SHALL, in MEASURE, increment the 8-bit echo count once every PRESCALE clocks, saturating at 255.
REQ-026 SHALL treat a count of 255 as the measurement end without waiting for echo fall.
REQ-027 SHALL end MEASURE on echo fall or on saturation.
REQ-028 SHALL, when count=0 at the end of MEASURE, pulse timeout, skip the divider, and go to HOLD, because the divider never completes on zero.
REQ-029 SHALL, when count is nonzero, assert div_clr for exactly one clock in CLR, then enter CALC.
REQ-030 SHALL, in CALC, hold calculate=1 and count stable until div_done=1.
REQ-031 SHALL, on div_done, latch div_d into distance, pulse valid, drop calculate the next clock, and go to HOLD.
REQ-032 SHALL, if DIV_TIMEOUT clocks elapse in CALC, pulse timeout, leave distance unchanged, and go to HOLD.
REQ-033 SHALL remain in HOLD until PERIOD_CYCLES clocks have elapsed since the trig rise, then go to TRIG if start=1, else to IDLE.
REQ-034 SHALL let start=0 mid-measurement finish the current cycle; no abort.
REQ-035 SHALL never let valid and timeout be high in the same clock.
REQ-036 SHALL size all internal counters to their parameter using $clog2.

Reset
REQ-037 SHALL, while reset=0, force state to IDLE; trig, div_clr, calculate, valid, timeout, busy to 0; count and distance to 0; all counters and synchronizer flops to 0.
REQ-038 SHALL, when reset is asserted mid-operation, drop calculate and trig immediately (asynchronous), with no valid pulse.

Structure
REQ-039 SHALL place the state enumeration and the default parameter constants in a shared package, us_pkg.
REQ-040 SHALL use one sub-module, us_echo_timer (synchronizer, prescaler, saturating counter); the FSM SHALL stay in the top module.

Verification (TRIG_CYCLES=10, PRESCALE=4, ECHO_TIMEOUT=200, PERIOD_CYCLES=1000, DIV_TIMEOUT=16)
REQ-041 SHALL cover: start=1, echo high for 40 clocks, divider model returns count>>1 after 3 clocks -> trig 10 clocks wide, count=10, distance=5, one valid pulse.
REQ-042 SHALL cover: echo never rises -> timeout pulse 200 clocks after WAIT_ECHO entry, next trig rise 1000 clocks after the previous one.
REQ-043 SHALL cover: echo held high for 2000 clocks -> count saturates at 255 and calculate asserts without echo fall.
REQ-044 SHALL cover: echo high for 2 clocks -> count=0, timeout pulse, calculate and div_clr never asserted.
REQ-045 SHALL cover: div_done held low -> timeout 16 clocks after CALC entry, distance keeps its previous value.
REQ-046 SHALL cover: reset driven low during CALC -> calculate=0 and busy=0 within the same clock, distance=0.

Source files
------------

// File: rtl/us_pkg.sv
// rtl/us_pkg.sv - shared state encoding, default parameters and sizing helper
package us_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_TRIG,
        ST_WAIT_ECHO,
        ST_MEASURE,
        ST_CLR,
        ST_CALC,
        ST_HOLD
    } us_state_t;

    localparam int DEF_TRIG_CYCLES   = 10;
    localparam int DEF_PRESCALE      = 58;
    localparam int DEF_ECHO_TIMEOUT  = 30000;
    localparam int DEF_PERIOD_CYCLES = 60000;
    localparam int DEF_DIV_TIMEOUT   = 16;

    localparam logic [7:0] COUNT_MAX = 8'hFF;

    // Width of a counter that walks 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ultrasonic_sequencer_if.sv
// rtl/ultrasonic_sequencer_if.sv - sequencer-to-divider handshake bundle
interface ultrasonic_sequencer_if;
    logic       div_clr;
    logic       calculate;
    logic [7:0] count;
    logic       div_done;
    logic [7:0] div_d;

    modport master (output div_clr, output calculate, output count,
                    input  div_done, input  div_d);
    modport slave  (input  div_clr, input  calculate, input  count,
                    output div_done, output div_d);
endinterface

// File: rtl/us_echo_timer.sv
// rtl/us_echo_timer.sv - echo synchronizer, edge detect, prescaler and saturating tick counter
module us_echo_timer
    import us_pkg::*;
#(
    parameter int PRESCALE = DEF_PRESCALE
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       echo_i,
    input  logic       clear_i,
    input  logic       run_i,
    output logic       echo_s_o,
    output logic       echo_rise_o,
    output logic [7:0] count_o,
    output logic       sat_o
);

    localparam int             PW       = cnt_w(PRESCALE);
    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);

    logic          sync1_q, sync2_q, prev_q;
    logic [PW-1:0] pre_q, pre_d;
    logic [7:0]    count_q, count_d;

    // Only clocks that see the synchronized echo high are counted, so the
    // tick count tracks the echo pulse width regardless of FSM latency.
    always_comb begin
        pre_d   = pre_q;
        count_d = count_q;
        if (clear_i) begin
            pre_d   = '0;
            count_d = '0;
        end else if (run_i && sync2_q) begin
            if (pre_q == PRE_LAST) begin
                pre_d = '0;
                if (count_q != COUNT_MAX) begin
                    count_d = count_q + 8'd1;
                end
            end else begin
                pre_d = pre_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
            pre_q   <= '0;
            count_q <= '0;
        end else begin
            sync1_q <= echo_i;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
            pre_q   <= pre_d;
            count_q <= count_d;
        end
    end

    assign echo_s_o    = sync2_q;
    assign echo_rise_o = sync2_q & ~prev_q;
    assign count_o     = count_q;
    assign sat_o       = (count_q == COUNT_MAX);

endmodule

// File: rtl/ultrasonic_sequencer.sv
// rtl/ultrasonic_sequencer.sv - ultrasonic ranging sequencer: trigger, echo timing, divider handshake
module ultrasonic_sequencer
    import us_pkg::*;
#(
    parameter int TRIG_CYCLES   = DEF_TRIG_CYCLES,
    parameter int PRESCALE      = DEF_PRESCALE,
    parameter int ECHO_TIMEOUT  = DEF_ECHO_TIMEOUT,
    parameter int PERIOD_CYCLES = DEF_PERIOD_CYCLES,
    parameter int DIV_TIMEOUT   = DEF_DIV_TIMEOUT
) (
    input  logic       CLKOUTD,
    input  logic       reset,
    input  logic       start,
    input  logic       echo,
    output logic       trig,
    output logic       div_clr,
    output logic       calculate,
    output logic [7:0] count,
    input  logic       div_done,
    input  logic [7:0] div_d,
    output logic [7:0] distance,
    output logic       valid,
    output logic       timeout,
    output logic       busy
);

    localparam int            TW     = cnt_w(TRIG_CYCLES);
    localparam int            WW     = cnt_w(ECHO_TIMEOUT);
    localparam int            DW     = cnt_w(DIV_TIMEOUT);
    localparam int            PCW    = cnt_w(PERIOD_CYCLES);
    localparam logic [TW-1:0]  T_LAST = TW'(TRIG_CYCLES - 1);
    localparam logic [WW-1:0]  W_LAST = WW'(ECHO_TIMEOUT - 1);
    localparam logic [DW-1:0]  D_LAST = DW'(DIV_TIMEOUT - 1);
    localparam logic [PCW-1:0] P_LAST = PCW'(PERIOD_CYCLES - 1);

    us_state_t      state_q;
    logic           trig_q, div_clr_q, calc_q, valid_q, timeout_q, busy_q;
    logic [7:0]     dist_q;
    logic [TW-1:0]  tcnt_q;
    logic [WW-1:0]  wcnt_q;
    logic [DW-1:0]  dcnt_q;
    logic [PCW-1:0] pcnt_q;

    logic       echo_s, echo_rise, sat;
    logic [7:0] echo_count;
    logic       timer_clear, timer_run;

    // The rise cycle itself is counted so the tick total matches the pulse width.
    assign timer_clear = (state_q == ST_TRIG);
    assign timer_run   = (state_q == ST_MEASURE) ||
                         ((state_q == ST_WAIT_ECHO) && echo_rise);

    us_echo_timer #(
        .PRESCALE (PRESCALE)
    ) u_echo_timer (
        .clk_i       (CLKOUTD),
        .rst_n_i     (reset),
        .echo_i      (echo),
        .clear_i     (timer_clear),
        .run_i       (timer_run),
        .echo_s_o    (echo_s),
        .echo_rise_o (echo_rise),
        .count_o     (echo_count),
        .sat_o       (sat)
    );

    always_ff @(posedge CLKOUTD or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            trig_q    <= 1'b0;
            div_clr_q <= 1'b0;
            calc_q    <= 1'b0;
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            busy_q    <= 1'b0;
            dist_q    <= '0;
            tcnt_q    <= '0;
            wcnt_q    <= '0;
            dcnt_q    <= '0;
            pcnt_q    <= '0;
        end else begin
            valid_q   <= 1'b0;
            timeout_q <= 1'b0;
            div_clr_q <= 1'b0;
            // Period counter measures time since the last trig rise; restarted on every rise.
            if (pcnt_q != P_LAST) begin
                pcnt_q <= pcnt_q + 1'b1;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_q <= ST_TRIG;
                        trig_q  <= 1'b1;
                        busy_q  <= 1'b1;
                        tcnt_q  <= '0;
                        pcnt_q  <= '0;
                    end
                end
                ST_TRIG: begin
                    if (tcnt_q == T_LAST) begin
                        trig_q  <= 1'b0;
                        wcnt_q  <= '0;
                        state_q <= ST_WAIT_ECHO;
                    end else begin
                        tcnt_q <= tcnt_q + 1'b1;
                    end
                end
                ST_WAIT_ECHO: begin
                    if (echo_rise) begin
                        state_q <= ST_MEASURE;
                    end else if (wcnt_q == W_LAST) begin
                        timeout_q <= 1'b1;
                        state_q   <= ST_HOLD;
                    end else begin
                        wcnt_q <= wcnt_q + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    if (!echo_s || sat) begin
                        // A zero count would hang the divider, so it is reported as an abort.
                        if (echo_count == 8'd0) begin
                            timeout_q <= 1'b1;
                            state_q   <= ST_HOLD;
                        end else begin
                            div_clr_q <= 1'b1;
                            state_q   <= ST_CLR;
                        end
                    end
                end
                ST_CLR: begin
                    calc_q  <= 1'b1;
                    dcnt_q  <= '0;
                    state_q <= ST_CALC;
                end
                ST_CALC: begin
                    if (div_done) begin
                        dist_q  <= div_d;
                        valid_q <= 1'b1;
                        calc_q  <= 1'b0;
                        state_q <= ST_HOLD;
                    end else if (dcnt_q == D_LAST) begin
                        timeout_q <= 1'b1;
                        calc_q    <= 1'b0;
                        state_q   <= ST_HOLD;
                    end else begin
                        dcnt_q <= dcnt_q + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (pcnt_q == P_LAST) begin
                        if (start) begin
                            state_q <= ST_TRIG;
                            trig_q  <= 1'b1;
                            tcnt_q  <= '0;
                            pcnt_q  <= '0;
                        end else begin
                            state_q <= ST_IDLE;
                            busy_q  <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    trig_q  <= 1'b0;
                    calc_q  <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign trig      = trig_q;
    assign div_clr   = div_clr_q;
    assign calculate = calc_q;
    assign count     = echo_count;
    assign distance  = dist_q;
    assign valid     = valid_q;
    assign timeout   = timeout_q;
    assign busy      = busy_q;

endmodule
